// File: rtl/imm_gen_pkg.sv
// Shared opcodes, format codes and S2 flag payload for the immediate generator.
package imm_gen_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_OP_32  = 7'b0111011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_CSR   = 3'd7
   } fmt_e;

   // Width-independent part of the S2 payload; imm/target/tag scale with parameters.
   typedef struct packed {
      fmt_e fmt;
      logic illegal;
   } s2_info_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side handshake bundle: instruction in, extended immediate and target out.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) ();
   import imm_gen_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [XLEN-1:0]  out_target;
   fmt_e             out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_inst, in_pc, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal, out_tag
   );

   modport slave (
      input  in_valid, in_inst, in_pc, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_extract.sv
// Combinational instruction-format decoder producing format, extended immediate and illegal flag.
// SYSTEM/CSR decoding is enabled by defining IMM_GEN_ZICSR_EN.
module imm_extract
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   output fmt_e            fmt_o,
   output logic [XLEN-1:0] imm_o,
   output logic            illegal_o
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            is_shift;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh5;

   assign opcode   = inst_i[6:0];
   assign funct3   = inst_i[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   // Size casts of signed operands sign-extend to XLEN for both legal widths.
   assign imm_i   = XLEN'($signed(inst_i[31:20]));
   assign imm_s   = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
   assign imm_b   = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
   assign imm_u   = XLEN'($signed({inst_i[31:12], 12'b0}));
   assign imm_j   = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
   assign imm_sh  = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
   assign imm_sh5 = XLEN'(inst_i[24:20]);

`ifdef IMM_GEN_ZICSR_EN
   logic [XLEN-1:0] imm_uimm, imm_csr;
   assign imm_uimm = XLEN'(inst_i[19:15]);
   assign imm_csr  = XLEN'(inst_i[31:20]);
`endif

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      fmt_o     = FMT_NONE;
      imm_o     = '0;
      illegal_o = 1'b0;
      case (opcode)
         OP_LOAD, OP_JALR: begin
            fmt_o = FMT_I;
            imm_o = imm_i;
         end
         OP_IMM: begin
            fmt_o = is_shift ? FMT_SHAMT : FMT_I;
            imm_o = is_shift ? imm_sh : imm_i;
         end
         OP_STORE: begin
            fmt_o = FMT_S;
            imm_o = imm_s;
         end
         OP_BRANCH: begin
            fmt_o = FMT_B;
            imm_o = imm_b;
         end
         OP_LUI, OP_AUIPC: begin
            fmt_o = FMT_U;
            imm_o = imm_u;
         end
         OP_JAL: begin
            fmt_o = FMT_J;
            imm_o = imm_j;
         end
         OP_IMM_32: begin
            if (XLEN == 64) begin
               fmt_o = is_shift ? FMT_SHAMT : FMT_I;
               imm_o = is_shift ? imm_sh5 : imm_i;
            end else begin
               illegal_o = 1'b1;
            end
         end
         OP_OP_32: illegal_o = (XLEN != 64);
         OP_OP, OP_FENCE: begin
         end
`ifdef IMM_GEN_ZICSR_EN
         OP_SYSTEM: begin
            if (funct3[2]) begin
               fmt_o = FMT_CSR;
               imm_o = imm_uimm;
            end else if (funct3 != 3'b000) begin
               fmt_o = FMT_CSR;
               imm_o = imm_csr;
            end
         end
`endif
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: S1 holds the raw instruction, S2 the decoded result.
// Optional CSR decoding is controlled by the IMM_GEN_ZICSR_EN macro (see imm_extract).
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   imm_gen_pipe_if.slave    bus,
   output logic [CNT_W-1:0] stat_illegal
);

   logic             s1_valid_q, s1_valid_d;
   logic [31:0]      s1_inst_q, s1_inst_d;
   logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic [XLEN-1:0]  s2_imm_q, s2_imm_d;
   logic [XLEN-1:0]  s2_target_q, s2_target_d;
   s2_info_t         s2_info_q, s2_info_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic [CNT_W-1:0] stat_q, stat_d;

   fmt_e             dec_fmt;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_illegal;

   logic s2_adv, s1_adv, in_ready, in_fire, s1_move, deliver;

   assign s2_adv   = !s2_valid_q | bus.out_ready;
   assign s1_adv   = !s1_valid_q | s2_adv;
   assign in_ready = rst_n & s1_adv & !flush;
   assign in_fire  = bus.in_valid & in_ready;
   assign s1_move  = s1_valid_q & s2_adv & !flush;
   assign deliver  = s2_valid_q & bus.out_ready;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .inst_i    (s1_inst_q),
      .fmt_o     (dec_fmt),
      .imm_o     (dec_imm),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_inst_d   = s1_inst_q;
      s1_pc_d     = s1_pc_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      s2_imm_d    = s2_imm_q;
      s2_target_d = s2_target_q;
      s2_info_d   = s2_info_q;
      s2_tag_d    = s2_tag_q;
      stat_d      = stat_q;

      if (in_fire) begin
         s1_inst_d = bus.in_inst;
         s1_pc_d   = bus.in_pc;
         s1_tag_d  = bus.in_tag;
      end
      if (flush)       s1_valid_d = 1'b0;
      else if (s1_adv) s1_valid_d = bus.in_valid;

      if (s1_move) begin
         s2_imm_d    = dec_imm;
         s2_target_d = s1_pc_q + dec_imm;
         s2_info_d   = '{fmt: dec_fmt, illegal: dec_illegal};
         s2_tag_d    = s1_tag_q;
      end
      if (flush)       s2_valid_d = 1'b0;
      else if (s2_adv) s2_valid_d = s1_valid_q;

      // A result handed over in a flush cycle still counts as delivered.
      if (deliver && s2_info_q.illegal && (stat_q != '1))
         stat_d = stat_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_imm_q    <= '0;
         s2_target_q <= '0;
         s2_info_q   <= '0;
         s2_tag_q    <= '0;
         stat_q      <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         s2_imm_q    <= s2_imm_d;
         s2_target_q <= s2_target_d;
         s2_info_q   <= s2_info_d;
         s2_tag_q    <= s2_tag_d;
         stat_q      <= stat_d;
      end
   end

   // NOTE: S1 payload is never observed while s1_valid_q is low, so it needs no reset.
   always_ff @(posedge clk) begin
      s1_inst_q <= s1_inst_d;
      s1_pc_q   <= s1_pc_d;
      s1_tag_q  <= s1_tag_d;
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_imm     = s2_imm_q;
   assign bus.out_target  = s2_target_q;
   assign bus.out_fmt     = s2_info_q.fmt;
   assign bus.out_illegal = s2_info_q.illegal;
   assign bus.out_tag     = s2_tag_q;
   assign stat_illegal    = stat_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: arithmetic reference decoder plus an occupancy/age model of the pipe.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
   localparam int CNT_W = 2;
   localparam int STAT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  target;
      fmt_e             fmt;
      logic             ill;
      logic [TAG_W-1:0] tag;
      int               age;
   } exp_t;

   logic clk, rst_n, flush;
   logic [CNT_W-1:0] stat_illegal;
   int n_vec = 0;
   int n_bad = 0;

   imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .bus          (bus),
      .stat_illegal (stat_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sx(input longint v, input int bits);
      longint half = longint'(1) << (bits - 1);
      return (v >= half) ? v - (half << 1) : v;
   endfunction

   // Reference decode computed from field arithmetic on the instruction value.
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [XLEN-1:0] pc,
                                       input logic [TAG_W-1:0] tag);
      exp_t r;
      longint u = longint'(inst);
      int op = int'(u & 'h7F);
      int f3 = int'((u >> 12) & 7);
      longint v = 0;
      r.fmt = FMT_NONE;
      r.ill = 1'b0;
      case (op)
         'h03, 'h67: begin r.fmt = FMT_I; v = sx((u >> 20) & 'hFFF, 12); end
         'h13: begin
            if (f3 == 1 || f3 == 5) begin
               r.fmt = FMT_SHAMT;
               v = (u >> 20) & ((XLEN == 64) ? 63 : 31);
            end else begin
               r.fmt = FMT_I; v = sx((u >> 20) & 'hFFF, 12);
            end
         end
         'h23: begin r.fmt = FMT_S; v = sx((((u >> 25) & 127) << 5) | ((u >> 7) & 31), 12); end
         'h63: begin
            r.fmt = FMT_B;
            v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                   (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
         end
         'h37, 'h17: begin r.fmt = FMT_U; v = sx(u & 'hFFFFF000, 32); end
         'h6F: begin
            r.fmt = FMT_J;
            v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                   (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
         end
         'h1B: begin
            if (XLEN == 64) begin
               if (f3 == 1 || f3 == 5) begin r.fmt = FMT_SHAMT; v = (u >> 20) & 31; end
               else begin r.fmt = FMT_I; v = sx((u >> 20) & 'hFFF, 12); end
            end else r.ill = 1'b1;
         end
         'h3B: r.ill = (XLEN != 64);
         'h33, 'h0F: ;
`ifdef IMM_GEN_ZICSR_EN
         'h73: begin
            if (f3 >= 4) begin r.fmt = FMT_CSR; v = (u >> 15) & 31; end
            else if (f3 != 0) begin r.fmt = FMT_CSR; v = (u >> 20) & 'hFFF; end
         end
`endif
         default: r.ill = 1'b1;
      endcase
      r.imm    = XLEN'(v);
      r.target = XLEN'(longint'(pc) + v);
      r.tag    = tag;
      r.age    = 0;
      return r;
   endfunction

   // ---------------- compare process ----------------
   exp_t q[$];
   int   stat_exp = 0;
   bit   rst_seen = 1'b0;

   always @(negedge clk) begin
      logic exp_ready, exp_valid;
      if (!rst_n) begin
         check("rst_in_ready", 64'(bus.in_ready), 64'(0));
         if (rst_seen) begin
            check("rst_out_valid", 64'(bus.out_valid), 64'(0));
            check("rst_out_imm", 64'(bus.out_imm), 64'(0));
            check("rst_out_target", 64'(bus.out_target), 64'(0));
            check("rst_out_fmt", 64'(bus.out_fmt), 64'(0));
            check("rst_out_illegal", 64'(bus.out_illegal), 64'(0));
            check("rst_out_tag", 64'(bus.out_tag), 64'(0));
            check("rst_stat", 64'(stat_illegal), 64'(0));
         end
         rst_seen = 1'b1;
         q.delete();
         stat_exp = 0;
      end else begin
         rst_seen  = 1'b0;
         exp_ready = !flush && (q.size() < 2 || bus.out_ready);
         exp_valid = (q.size() > 0) && (q[0].age >= 2);
         check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
         check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
         check("stat_illegal", 64'(stat_illegal), 64'(stat_exp));
         if (exp_valid && bus.out_valid) begin
            check("out_imm", 64'(bus.out_imm), 64'(q[0].imm));
            check("out_target", 64'(bus.out_target), 64'(q[0].target));
            check("out_fmt", 64'(bus.out_fmt), 64'(q[0].fmt));
            check("out_illegal", 64'(bus.out_illegal), 64'(q[0].ill));
            check("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
         end
         if (exp_valid && bus.out_ready) begin
            if (q[0].ill && stat_exp < STAT_MAX) stat_exp++;
            void'(q.pop_front());
         end
         if (flush) q.delete();
         else if (bus.in_valid && exp_ready)
            q.push_back(ref_decode(bus.in_inst, bus.in_pc, bus.in_tag));
         foreach (q[i]) q[i].age++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [31:0] inst, input logic [XLEN-1:0] pc,
                       input logic [TAG_W-1:0] tag);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      bus.in_tag   = tag;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_accept_timeout", 64'(n < 50), 64'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t r;
      logic [XLEN-1:0] held_imm;
      logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                               7'h6F, 7'h1B, 7'h3B, 7'h33, 7'h0F, 7'h73, 7'h7F};

      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.in_tag = '0;
      bus.out_ready = 1'b1;

      // Pin the reference model with hand-derived values.
      r = ref_decode(32'hFFF00093, 32'h0, 4'd0);
      check("pin_addi_imm", 64'(r.imm), 64'hFFFFFFFF);
      check("pin_addi_fmt", 64'(r.fmt), 64'(FMT_I));
      r = ref_decode(32'hFE000EE3, 32'h100, 4'd0);
      check("pin_beq_imm", 64'(r.imm), 64'hFFFFFFFC);
      check("pin_beq_target", 64'(r.target), 64'h000000FC);
      r = ref_decode(32'h123452B7, 32'h0, 4'd0);
      check("pin_lui_imm", 64'(r.imm), 64'h12345000);
      r = ref_decode(32'h001000EF, 32'h0, 4'd0);
      check("pin_jal_target", 64'(r.target), 64'h800);
      r = ref_decode(32'h01F09093, 32'h0, 4'd0);
      check("pin_slli_imm", 64'(r.imm), 64'h1F);
      check("pin_slli_fmt", 64'(r.fmt), 64'(FMT_SHAMT));
      r = ref_decode(32'h0000007F, 32'h40, 4'd0);
      check("pin_bad_ill", 64'(r.ill), 64'(1));
      check("pin_bad_target", 64'(r.target), 64'h40);

      idle(3);
      rst_n = 1'b1;
      idle(1);

      // Two-cycle latency for addi x1,x0,-1.
      send(32'hFFF00093, 32'h0, 4'd1);
      @(negedge clk);
      check("lat_not_yet", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      check("lat_valid", 64'(bus.out_valid), 64'(1));
      check("addi_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
      check("addi_fmt", 64'(bus.out_fmt), 64'(FMT_I));
      @(posedge clk); #1;

      send(32'hFE000EE3, 32'h100, 4'd2);
      @(negedge clk);
      @(negedge clk);
      check("beq_imm", 64'(bus.out_imm), 64'hFFFFFFFC);
      check("beq_target", 64'(bus.out_target), 64'h000000FC);
      check("beq_fmt", 64'(bus.out_fmt), 64'(FMT_B));
      @(posedge clk); #1;

      // Back-to-back stream, consumer always ready.
      send(32'h123452B7, 32'h0, 4'd3);
      send(32'h001000EF, 32'h0, 4'd4);
      send(32'h01F09093, 32'h0, 4'd5);
      idle(4);

      // Stall: two entries held, third offered but refused.
      bus.out_ready = 1'b0;
      send(32'h00A00513, 32'h10, 4'd6);
      send(32'h00112623, 32'h14, 4'd7);
      bus.in_valid = 1'b1; bus.in_inst = 32'h00000463; bus.in_pc = 32'h18; bus.in_tag = 4'd8;
      @(negedge clk);
      held_imm = bus.out_imm;
      repeat (5) begin
         check("stall_in_ready", 64'(bus.in_ready), 64'(0));
         check("stall_tag", 64'(bus.out_tag), 64'(6));
         check("stall_imm", 64'(bus.out_imm), 64'(held_imm));
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      idle(4);

      // Flush with both stages full; offered input in the flush cycle is dropped.
      bus.out_ready = 1'b0;
      send(32'h00100093, 32'h20, 4'd9);
      send(32'h00200113, 32'h24, 4'd10);
      bus.in_valid = 1'b1; bus.in_inst = 32'h00300193; bus.in_pc = 32'h28; bus.in_tag = 4'd11;
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(bus.in_ready), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      check("flush_cleared", 64'(bus.out_valid), 64'(0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("flush_resume_tag", 64'(bus.out_tag), 64'(11));
      idle(3);

      // Reset in the middle of a stall drops everything.
      bus.out_ready = 1'b0;
      send(32'h0000007F, 32'h30, 4'd12);
      send(32'h0000007F, 32'h34, 4'd13);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_stall_valid", 64'(bus.out_valid), 64'(0));
      check("rst_stall_stat", 64'(stat_illegal), 64'(0));
      @(posedge clk); #1;

      // Illegal counter saturation at CNT_W=2.
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) send(32'h0000007F, 32'(k * 4), 4'(k));
      send(32'h00000073, 32'h50, 4'd4);
      idle(4);
      check("stat_saturated", 64'(stat_illegal), 64'(STAT_MAX));

      // Randomised traffic with backpressure, flushes and rare resets.
      for (int c = 0; c < 3000; c++) begin
         rst_n         = ($urandom_range(0, 299) != 0);
         flush         = ($urandom_range(0, 29) == 0);
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_inst   = {$urandom_range(0, 32'h01FF_FFFF) , ops[$urandom_range(0, 13)]};
         if ($urandom_range(0, 15) == 0) bus.in_inst = $urandom;
         bus.in_pc     = $urandom;
         bus.in_tag    = TAG_W'($urandom);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk); #1;
      end

      rst_n = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction word plus its PC per cycle over a valid/ready handshake and classifies the instruction format. It produces the sign- or zero-extended XLEN-wide immediate, the PC-relative target (pc + imm), and an illegal-opcode flag two cycles later. It supports backpressure from the execute side and a flush from branch resolution.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 4: width of the sideband tag (ROB/slot id) carried alongside each instruction.
- CNT_W, 16: width of the saturating illegal-instruction counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- flush  in  1  discards all in-flight entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_imm  out  XLEN  extended immediate.
- out_target  out  XLEN  pc + imm, modulo 2^XLEN.
- out_fmt  out  3  format code (package enum).
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the result.
- stat_illegal  out  CNT_W  count of illegal results delivered.

## Operation
- Stage 1 (S1): registers inst, pc, and tag, and decodes the format from inst[6:0]. Stage 2 (S2): registers imm, target, fmt, illegal, and tag.
- Formats:
  - I: opcodes 0000011, 0010011, and 1100111; imm = sext(inst[31:20]).
  - SHAMT: opcode 0010011 with funct3 = 001/101; imm = zext(inst[24:20]) when XLEN=32, zext(inst[25:20]) when XLEN=64.
  - S: opcode 0100011; imm = sext({inst[31:25], inst[11:7]}).
  - B: opcode 1100011; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: opcodes 0110111 and 0010111; imm = sext({inst[31:12], 12'b0}).
  - J: opcode 1101111; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Opcodes 0011011 and 0111011 with XLEN=64: opcode 0011011 is I/SHAMT (shamt is 5 bits); opcode 0111011 is NONE. With XLEN=32, both are illegal.
  - R-type (0110011), FENCE (0001111): fmt NONE, imm 0, legal.
  - Any other opcode: fmt NONE, imm 0, target = pc, out_illegal = 1.
- out_target is computed for every entry. It is meaningful to consumers only for B, J, and AUIPC.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv & !flush.
  - Transfer occurs when valid & ready are both high.
- stat_illegal increments when out_valid & out_ready & out_illegal. It saturates at all-ones and does not wrap.
- flush: clears s1_valid and s2_valid at the next edge. The input is not accepted in the flush cycle. stat_illegal is not affected.
- Reset values: out_valid=0; out_imm, out_target, out_fmt, out_tag=0; out_illegal=0; stat_illegal=0; in_ready=0 while rst_n is low.

## Timing
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+1. That is two register stages.
- Throughput: 1 instruction per cycle when out_ready stays high.
- Stall: while out_valid & !out_ready, all out_* are held stable. S1 keeps its entry, and in_ready drops once S1 is occupied.
- Stall released: a full pipeline drains at one entry per cycle. No bubbles are inserted.
- Flush and out_ready high in the same cycle: the current S2 entry counts as delivered. Both stages are empty after the edge.
- Reset asserted mid-stall: all entries are dropped. There is no partial output.

## Configuration
- IMM_GEN_ZICSR_EN defined: opcode 1110011 is decoded.
  - funct3[2]=1: fmt CSR, imm = zext(inst[19:15]).
  - funct3[2]=0 and funct3 != 0: fmt CSR, imm = zext(inst[31:20]) (CSR address).
  - funct3=0: fmt NONE, legal.
- IMM_GEN_ZICSR_EN undefined: opcode 1110011 is illegal.

## Structure
- Package imm_gen_pkg holds:
  - the opcode localparams;
  - the fmt_e enum (NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, CSR=7);
  - a packed struct for the S2 payload.
- One sub-module, imm_extract: a combinational decoder from inst to {fmt, imm, illegal}, parametrised by XLEN. It is instantiated between S1 and S2.

## Test plan
- XLEN=32, in_inst=0xFFF00093 (addi x1,x0,-1), pc=0x0: out_imm=0xFFFFFFFF, fmt I, 2-cycle latency.
- in_inst=0xFE000EE3 (beq -4), pc=0x100: out_imm=0xFFFFFFFC, out_target=0x000000FC, fmt B.
- Back-to-back 0x123452B7 (lui), 0x001000EF (jal +2048, pc=0), 0x01F09093 (slli 31), with out_ready=1 throughout:
  - imm 0x12345000 (U), then imm 0x800 with target 0x800 (J), then imm 0x1F (SHAMT);
  - results on consecutive cycles.
- out_ready held low for 5 cycles during a stream: at most 2 entries are held, outputs stay stable, no loss or duplication after release.
- flush asserted with both stages full: out_valid=0 on the next cycle, the flush-cycle input is not accepted, and the tag order resumes with the next input.
- Repeated opcode 0x7F with CNT_W=2: out_illegal=1 and imm=0 on each result; stat_illegal counts 1, 2, 3, 3 (saturates). Opcode 1110011 is also illegal when IMM_GEN_ZICSR_EN is undefined.
